// File: rtl/delay_probe_pkg.sv
// Shared types and default constants for the delay_probe round-trip latency meter.
package delay_probe_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned TIMEOUT_DEF     = 1000;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/delay_probe_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronous active-high reset.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_d;
    logic [SYNC_STAGES-1:0] stage_q;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/delay_probe.sv
// Launches an edge into an external delay chain and counts clock edges until the
// synchronized return changes, with a timeout for chains that never answer.
module delay_probe
    import delay_probe_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             probe_out,
    input  logic             probe_in,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] latency
);

    state_e           state_q, state_d;
    logic             probe_out_q, probe_out_d;
    logic             ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             timed_out_q, timed_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_inc;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (probe_in),
        .q  (sync_q)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and output logic; busy/done are decoded from the next state so they stay registered.
    always_comb begin
        state_d     = state_q;
        probe_out_d = probe_out_q;
        ref_d       = ref_q;
        cnt_d       = cnt_q;
        latency_d   = latency_q;
        timed_out_d = timed_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    probe_out_d = ~probe_out_q;
                    ref_d       = sync_q;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Any change versus the launch-time sample counts, so chain polarity is irrelevant.
                if (sync_q != ref_q) begin
                    latency_d   = cnt_inc;
                    timed_out_d = 1'b0;
                    state_d     = DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    latency_d   = CNT_W'(TIMEOUT);
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            probe_out_q <= 1'b0;
            ref_q       <= 1'b0;
            cnt_q       <= '0;
            latency_q   <= '0;
            timed_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            probe_out_q <= probe_out_d;
            ref_q       <= ref_d;
            cnt_q       <= cnt_d;
            latency_q   <= latency_d;
            timed_out_q <= timed_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign probe_out = probe_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;
    assign latency   = latency_q;

endmodule

// File: tb/tb_delay_probe.sv
// Directed bench for delay_probe: loopback, inverted loopback, 10-stage chain, timeout,
// mid-measurement reset and ignored start requests.
module tb_delay_probe;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        probe_in;
    logic        probe_out;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] latency;

    int          tests = 0;
    int          fails = 0;
    int          dcount = 0;
    int          tcount = 0;
    logic        prev_po = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] ch;

    delay_probe #(
        .CNT_W      (16),
        .TIMEOUT    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .probe_out(probe_out),
        .probe_in (probe_in),
        .busy     (busy),
        .done     (done),
        .timed_out(timed_out),
        .latency  (latency)
    );

    always #2 clk = ~clk;

    // Ten 1-unit inverters: even count, so the chain is non-inverting with 10 units of delay.
    assign ch[0] = probe_out;
    for (genvar i = 0; i < 10; i++) begin : g_chain
        assign #1 ch[i+1] = ~ch[i];
    end

    always_comb begin
        case (mode)
            2'd0:    probe_in = probe_out;
            2'd1:    probe_in = ~probe_out;
            2'd2:    probe_in = ch[10];
            default: probe_in = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (done === 1'b1) dcount++;
        if (probe_out !== prev_po) tcount++;
        prev_po = probe_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one measurement and return the number of edges after launch until done rises.
    task automatic measure(input string tag, output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        int t0;
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("rst_probe_out", 32'(probe_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_latency", 32'(latency), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Zero-delay loopback
        measure("lb", n);
        chk("lb_edges", 32'(n), 32'd3);
        chk("lb_latency", 32'(latency), 32'd3);
        chk("lb_timed_out", 32'(timed_out), 32'd0);
        chk("lb_probe_out", 32'(probe_out), 32'd1);
        chk("lb_busy_in_done", 32'(busy), 32'd0);
        tick();
        chk("lb_done_one_cycle", 32'(done), 32'd0);
        chk("lb_latency_held", 32'(latency), 32'd3);

        // Inverted loopback
        mode = 2'd1;
        repeat (4) tick();
        measure("inv", n);
        chk("inv_edges", 32'(n), 32'd3);
        chk("inv_latency", 32'(latency), 32'd3);
        chk("inv_probe_out", 32'(probe_out), 32'd0);

        // 10-stage chain, 10 units of delay against a 4-unit clock
        mode = 2'd2;
        repeat (6) tick();
        measure("chain1", n);
        chk("chain1_latency", 32'(latency), 32'd5);
        chk("chain1_timed_out", 32'(timed_out), 32'd0);
        chk("chain1_probe_out", 32'(probe_out), 32'd1);
        repeat (6) tick();
        measure("chain2", n);
        chk("chain2_latency", 32'(latency), 32'd5);
        chk("chain2_probe_out", 32'(probe_out), 32'd0);

        // Return tied low: timeout after 8 edges
        mode = 2'd3;
        repeat (4) tick();
        measure("to", n);
        chk("to_edges", 32'(n), 32'd8);
        chk("to_latency", 32'(latency), 32'd8);
        chk("to_timed_out", 32'(timed_out), 32'd1);
        tick();
        chk("to_done_cleared", 32'(done), 32'd0);
        chk("to_timed_out_held", 32'(timed_out), 32'd1);

        // Reset in the second WAIT cycle
        mode = 2'd0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_busy_before", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_probe_out", 32'(probe_out), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_timed_out", 32'(timed_out), 32'd0);
        chk("mid_latency", 32'(latency), 32'd0);
        repeat (3) tick();
        measure("post_rst", n);
        chk("post_rst_latency", 32'(latency), 32'd3);
        chk("post_rst_edges", 32'(n), 32'd3);

        // start during WAIT and during DONE must be ignored
        repeat (3) tick();
        d0 = dcount;
        t0 = tcount;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ign_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy_after_done", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("ign_done_pulses", 32'(dcount - d0), 32'd1);
        chk("ign_toggles", 32'(tcount - t0), 32'd1);
        chk("ign_latency", 32'(latency), 32'd3);

        // start coincident with reset
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_probe_out", 32'(probe_out), 32'd0);
        tick();
        chk("rst_start_busy_later", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/delay_probe.md
DELAY_PROBE -- requirements
Module: delay_probe

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, the latency counter width.
REQ-002 The module SHALL have parameter TIMEOUT, default 1000, the WAIT cycles before abort; legal range 1 .. 2^CNT_W-1.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, the flops on the return path; minimum 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: single-cycle request to launch one measurement.
REQ-007 The module SHALL have port probe_out, output, 1 bit: registered edge driven into the delay chain input.
REQ-008 The module SHALL have port probe_in, input, 1 bit: delay chain output, asynchronous to clk.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a measurement is in flight.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when a measurement ends.
REQ-011 The module SHALL have port timed_out, output, 1 bit: valid with done; high if no return edge arrived; held until the next launch.
REQ-012 The module SHALL have port latency, output, CNT_W bits: clock edges from launch to detection; held until the next launch.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-014 IDLE SHALL have busy=0 and done=0.
- start=1 at edge E0: probe_out toggles; ref is set to the current synchronized return bit (sync_q); cnt is cleared to 0; timed_out is cleared; next state is WAIT.
REQ-015 In WAIT, busy SHALL be 1, and at each edge:
- sync_q != ref: latency is set to cnt+1; timed_out is set to 0; next state is DONE.
- otherwise, cnt+1 == TIMEOUT: latency is set to TIMEOUT; timed_out is set to 1; next state is DONE.
- otherwise: cnt increments.
REQ-016 DONE SHALL last exactly one cycle, with done=1 and busy=0, and SHALL always return to IDLE.
REQ-017 start SHALL be ignored in WAIT and DONE and SHALL NOT be queued; a start coincident with DONE has no effect.
REQ-018 Detection SHALL be polarity-independent (any change of sync_q versus ref), so chains with odd or even inverter counts both work.
REQ-019 probe_out SHALL toggle only on launch and SHALL hold its level otherwise.
REQ-020 Zero-delay loopback SHALL yield latency = SYNC_STAGES+1.
REQ-021 cnt SHALL never wrap; the TIMEOUT range in REQ-002 guarantees this.
REQ-022 probe_in SHALL reach FSM logic only through the synchronizer; no combinational path from probe_in to any output.
REQ-023 A return edge that arrives after a timeout SHALL be absorbed at the next launch, because ref is resampled then.

Reset
REQ-024 On rst=1 at any clock edge, including mid-measurement, the block SHALL set state=IDLE, probe_out=0, busy=0, done=0, timed_out=0, latency=0, cnt=0, ref=0, and all synchronizer flops to 0.
REQ-025 start coincident with rst SHALL be ignored, since rst has priority.

Structure
REQ-026 Package delay_probe_pkg SHALL hold the state enumeration (IDLE/WAIT/DONE) and the default constants for CNT_W, TIMEOUT and SYNC_STAGES.
REQ-027 One sub-module, bit_sync, SHALL be used:
- parameterized SYNC_STAGES flop chain with synchronous reset;
- instantiated once on probe_in.
REQ-028 All remaining logic (FSM, counter, ref, probe_out) SHALL reside in delay_probe; no latches and no gated clocks.

Verification
REQ-029 Zero-delay loopback (probe_in=probe_out), SYNC_STAGES=2, start at E0 -> done at E3, latency=3, timed_out=0, probe_out=1.
REQ-030 10-stage 1 ns inverter chain, clk period 4 ns, launch 1 ns clear of chain transitions -> latency=5; second start -> latency=5, probe_out back to 0.
REQ-031 probe_in tied 0, TIMEOUT=8 -> done 8 edges after launch, latency=8, timed_out=1.
REQ-032 rst asserted at the 2nd WAIT cycle -> next edge: all outputs 0, state IDLE; later start measures normally (latency=3 in loopback).
REQ-033 start pulsed during WAIT and during the DONE cycle -> exactly one done pulse, and probe_out toggled once.
REQ-034 Odd-inverter loopback (probe_in=~probe_out) -> latency=3, same as REQ-029.
